// File: rtl/mtl2_i2c_target.sv
// I2C target with an 8 x 8-bit register file.
// The target supports a pointer write, burst writes and burst reads,
// and the pointer auto-increments with wrap from 7 to 0.
// SCL and SDA are synchronized into clk; every bus decision uses the synchronized copies.
module mtl2_i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h38,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [63:0] regs_q,
  output logic        busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_hist_r;
  logic                   sda_hist_r;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic [7:0] rd_byte_s;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [2:0] ptr_r;
  logic       rw_r;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_hist_r;
  assign scl_fall_s = ~scl_s & scl_hist_r;
  // SCL must be high in both the current and the previous sample so that an
  // SDA move that is racing an SCL edge is not taken as START or STOP.
  assign start_s    = scl_s & scl_hist_r & sda_hist_r & ~sda_s;
  assign stop_s     = scl_s & scl_hist_r & ~sda_hist_r & sda_s;
  assign rd_byte_s  = regs_q[{ptr_r, 3'b000} +: 8];

  // Pad synchronizers plus one history stage; reset to the idle-bus level (high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      scl_hist_r <= scl_s;
      sda_hist_r <= sda_s;
    end
  end

  // Protocol FSM: samples SDA on SCL rise and changes the SDA drive only on SCL fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      ptr_r     <= 3'd0;
      rw_r      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 3'd0;
      wr_data   <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
              shift_r   <= {shift_r[6:0], sda_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              bit_cnt_r <= 4'd0;
              if (state_r == ST_ADDR) begin
                if (shift_r[7:1] == DEV_ADDR) begin
                  rw_r    <= shift_r[0];
                  sda_oe  <= 1'b1;
                  state_r <= ST_ADDR_ACK;
                end else begin
                  // Not addressed: stay silent until the next START or STOP
                  state_r <= ST_IDLE;
                end
              end else if (state_r == ST_PTR) begin
                ptr_r   <= shift_r[2:0];
                sda_oe  <= 1'b1;
                state_r <= ST_PTR_ACK;
              end else begin
                wr_strobe <= 1'b1;
                wr_addr   <= ptr_r;
                wr_data   <= shift_r;
                ptr_r     <= ptr_r + 3'd1;
                sda_oe    <= 1'b1;
                state_r   <= ST_WDATA_ACK;
              end
            end else begin
              state_r <= state_r;
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_r <= 4'd0;
              if (rw_r) begin
                // The ACK-ending fall is also the fall that launches read bit 7
                shift_r <= rd_byte_s;
                sda_oe  <= ~rd_byte_s[7];
                state_r <= ST_RDATA;
              end else begin
                sda_oe  <= 1'b0;
                state_r <= ST_PTR;
              end
            end else begin
              state_r <= ST_ADDR_ACK;
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_r <= 4'd0;
              sda_oe    <= 1'b0;
              state_r   <= ST_WDATA;
            end else begin
              state_r <= state_r;
            end
          end
          ST_RDATA: begin
            if (scl_rise_s && (bit_cnt_r != 4'd8)) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe  <= 1'b0;
                state_r <= ST_RDATA_ACK;
              end else begin
                shift_r <= {shift_r[6:0], 1'b0};
                sda_oe  <= ~shift_r[6];
              end
            end else begin
              state_r <= ST_RDATA;
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise_s) begin
              // Pointer advances whether the master ACKs or NACKs
              ptr_r <= ptr_r + 3'd1;
              if (sda_s) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_RDATA_ACK;
              end
            end else if (scl_fall_s) begin
              bit_cnt_r <= 4'd0;
              shift_r   <= rd_byte_s;
              sda_oe    <= ~rd_byte_s[7];
              state_r   <= ST_RDATA;
            end else begin
              state_r <= ST_RDATA_ACK;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Register file: commits the strobed byte on the clk after wr_strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= 64'd0;
    end else if (wr_strobe) begin
      regs_q[{wr_addr, 3'b000} +: 8] <= wr_data;
    end else begin
      regs_q <= regs_q;
    end
  end

endmodule

// File: tb/tb_mtl2_i2c_target.sv
// Randomized bench for mtl2_i2c_target.
// A bus-master model drives SCL and SDA, and a reference model of the
// register file and pointer predicts the behaviour.
// Expected writes go into a queue that an independent monitor drains on wr_strobe.
module tb_mtl2_i2c_target;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_oe;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [63:0] regs_q;
  logic        busy;
  wire         sda_line = sda_m & ~sda_oe;

  mtl2_i2c_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .regs_q    (regs_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic [7:0]  d;
    logic [63:0] r;
  } wexp_t;

  wexp_t       wq[$];
  logic [7:0]  wbytes[$];
  logic [7:0]  mregs[8];
  logic [2:0]  mptr;
  int          total = 0;
  int          bad = 0;
  logic        watch_oe = 1'b0;
  logic        oe_seen = 1'b0;
  logic        regs_pend = 1'b0;
  logic [63:0] pend_img;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] img();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = mregs[i];
    return v;
  endfunction

  // Monitor: pops the expected write whenever the DUT strobes, then checks regs_q a clk later
  always @(negedge clk) begin
    wexp_t e;
    if (regs_pend) begin
      chk("regs_after_wr", regs_q, pend_img);
      regs_pend = 1'b0;
    end
    if (reset_n && wr_strobe) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr_strobe: got addr=%0d data=%0h expected no strobe", wr_addr, wr_data);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", {61'd0, wr_addr}, {61'd0, e.a});
        chk("wr_data", {56'd0, wr_data}, {56'd0, e.d});
        pend_img  = e.r;
        regs_pend = 1'b1;
      end
    end
    if (watch_oe && sda_oe) oe_seen = 1'b1;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; hold(4);
    scl_m = 1'b1; hold(8);
    sda_m = 1'b0; hold(8);
    scl_m = 1'b0; hold(4);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; hold(4);
    scl_m = 1'b1; hold(8);
    sda_m = 1'b1; hold(8);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    hold(4);
    scl_m = 1'b1; hold(8);
    scl_m = 1'b0; hold(4);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; hold(4);
    scl_m = 1'b1; hold(4);
    b = sda_line; hold(4);
    scl_m = 1'b0; hold(4);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    chk("ack_level", {63'd0, a}, {63'd0, ~exp_ack});
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic do_write(input logic [7:0] p);
    wexp_t e;
    start_c();
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    write_byte(8'h70, 1'b1);
    write_byte(p, 1'b1);
    mptr = p[2:0];
    foreach (wbytes[i]) begin
      mregs[mptr] = wbytes[i];
      e.a = mptr;
      e.d = wbytes[i];
      e.r = img();
      wq.push_back(e);
      mptr = mptr + 3'd1;
      write_byte(wbytes[i], 1'b1);
    end
    stop_c();
    chk("busy_after_stop", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_read(input logic with_ptr, input logic [7:0] p, input int n);
    logic [7:0] d;
    logic [7:0] exp;
    start_c();
    if (with_ptr) begin
      write_byte(8'h70, 1'b1);
      write_byte(p, 1'b1);
      mptr = p[2:0];
      start_c();
    end
    write_byte(8'h71, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp  = mregs[mptr];
      mptr = mptr + 3'd1;
      read_byte(d, i != n - 1);
      chk("rd_data", {56'd0, d}, {56'd0, exp});
    end
    stop_c();
    chk("busy_after_rd", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_wrong();
    logic [6:0] a;
    a = 7'($urandom_range(0, 127));
    if (a == 7'h38) a = 7'h39;
    start_c();
    oe_seen  = 1'b0;
    watch_oe = 1'b1;
    write_byte({a, 1'($urandom_range(0, 1))}, 1'b0);
    chk("busy_wrong_addr", {63'd0, busy}, 64'd1);
    write_byte(8'($urandom_range(0, 255)), 1'b0);
    stop_c();
    watch_oe = 1'b0;
    chk("oe_seen_wrong_addr", {63'd0, oe_seen}, 64'd0);
    chk("busy_after_wrong", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [7:0] p;
    for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
    mptr = 3'd0;
    hold(5);
    chk("rst_sda_oe", {63'd0, sda_oe}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wr_strobe", {63'd0, wr_strobe}, 64'd0);
    chk("rst_wr_addr", {61'd0, wr_addr}, 64'd0);
    chk("rst_wr_data", {56'd0, wr_data}, 64'd0);
    chk("rst_regs", regs_q, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hold(10);

    // Burst write at pointer 2
    wbytes = '{8'hA5, 8'h5A};
    do_write(8'h02);
    // Pointer write, repeated start, read two bytes (ACK then NACK)
    do_read(1'b1, 8'h02, 2);
    // Pointer should now be 4: read without a pointer phase
    do_read(1'b0, 8'h00, 1);
    // Wrong address
    do_wrong();
    // Pointer wrap 7 -> 0
    wbytes = '{8'h11, 8'h22};
    do_write(8'h07);
    chk("wrap_reg7", {56'd0, regs_q[63:56]}, 64'h11);
    chk("wrap_reg0", {56'd0, regs_q[7:0]}, 64'h22);

    // STOP after four data bits: partial byte discarded
    start_c();
    write_byte(8'h70, 1'b1);
    write_byte(8'h05, 1'b1);
    mptr = 3'd5;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    stop_c();
    chk("partial_regs", regs_q, img());
    chk("partial_busy", {63'd0, busy}, 64'd0);
    do_read(1'b0, 8'h00, 1);

    // Reset during the address ACK
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 1'(8'h70 >> i));
    sda_m = 1'b1;
    hold(6);
    chk("oe_in_ack", {63'd0, sda_oe}, 64'd1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("oe_async_reset", {63'd0, sda_oe}, 64'd0);
    chk("regs_async_reset", regs_q, 64'd0);
    chk("busy_async_reset", {63'd0, busy}, 64'd0);
    for (int i = 0; i < 8; i++) mregs[i] = 8'd0;
    mptr = 3'd0;
    hold(3);
    scl_m = 1'b1;
    hold(3);
    @(negedge clk);
    reset_n = 1'b1;
    hold(10);
    wbytes = '{8'hC3, 8'h3C};
    do_write(8'h06);
    do_read(1'b1, 8'h06, 2);

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          wbytes.delete();
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) wbytes.push_back(8'($urandom_range(0, 255)));
          p = 8'($urandom_range(0, 255));
          do_write(p);
        end
        1: begin
          p = 8'($urandom_range(0, 255));
          do_read(1'($urandom_range(0, 1)), p, int'($urandom_range(1, 4)));
        end
        default: do_wrong();
      endcase
    end

    hold(4);
    chk("final_regs", regs_q, img());
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
